// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache. A hit answers in the same cycle.
// A miss fills one 256-bit line from physical memory through a single request.
module inst_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inst_read,
  input  logic [31:0]  inst_addr,
  output logic [31:0]  inst_rdata,
  output logic         inst_resp,
  output logic         pmem_read,
  output logic [31:0]  pmem_address,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t             state;
  state_t             state_next;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tags  [SETS];
  logic [255:0]       lines [SETS];
  logic [31:0]        fill_addr;

  logic [S_INDEX-1:0] idx;
  logic [S_INDEX-1:0] fill_idx;
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   fill_tag;
  logic [2:0]         word_sel;
  logic               hit;
  logic               latch_miss;
  logic               fill_done;
  logic               unused_bits;

  assign idx          = inst_addr[4+S_INDEX:5];
  assign tag          = inst_addr[31:5+S_INDEX];
  assign word_sel     = inst_addr[4:2];
  assign fill_idx     = fill_addr[4+S_INDEX:5];
  assign fill_tag     = fill_addr[31:5+S_INDEX];
  assign unused_bits  = ^inst_addr[1:0];

  assign hit          = inst_read && valid[idx] && (tags[idx] == tag);
  assign inst_rdata   = lines[idx][{word_sel, 5'b00000} +: 32];
  // The latched line address, not the live request, drives the fill.
  assign pmem_address = fill_addr;

  always_comb begin
    state_next = state;
    inst_resp  = 1'b0;
    pmem_read  = 1'b0;
    latch_miss = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          inst_resp = 1'b1;
        end else if (inst_read) begin
          latch_miss = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = IDLE;
        end
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fill_addr <= 32'h0000_0000;
      valid     <= {SETS{1'b0}};
    end else begin
      state <= state_next;
      if (latch_miss) begin
        fill_addr <= {inst_addr[31:5], 5'b00000};
      end
      if (fill_done) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are deliberately not reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      lines[fill_idx] <= pmem_rdata;
      tags[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache: a residency model predicts hit or
// miss latency and a fixed memory image predicts every returned word.
module tb_inst_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic [31:0]  inst_rdata;
  logic         inst_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  inst_cache #(.S_INDEX(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          exp_wait;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned resident[int];
  int          fill_delay = 0;
  int          cnt = 0;
  bit          busy = 1'b0;
  bit          auto_resp = 1'b1;
  int          wait_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w == 32'h0000_0064) return 32'h0010_0093;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word({a[31:5], 5'b00000} + 32'(4*k));
    return l;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i;
    i = int'((a >> 5) & 32'h7);
    return resident.exists(i) && (resident[i] == (a & 32'hFFFF_FFE0));
  endfunction

  function automatic void install(input logic [31:0] a);
    resident[int'((a >> 5) & 32'h7)] = a & 32'hFFFF_FFE0;
  endfunction

  // Advance one clock; the memory model answers a fill after fill_delay cycles.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_resp) begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        busy = 1'b0;
      end else if (pmem_read) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = fill_delay;
        end
        if (cnt == 0) begin
          pmem_rdata = mem_line(pmem_address);
          pmem_resp = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  endtask

  task automatic request(input logic [31:0] addr);
    bit   hit;
    bit   got;
    exp_t e;
    hit = model_hit(addr);
    e.addr = addr;
    e.data = mem_word(addr);
    e.exp_wait = hit ? 0 : fill_delay + 2;
    sb.push_back(e);
    inst_read = 1'b1;
    inst_addr = addr;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = inst_resp;
      if (got && hit) check("hit_no_fill", 32'(pmem_read), 32'd0);
      step();
      if (i == 0 && !hit) begin
        check("fill_req", 32'(pmem_read), 32'd1);
        check("fill_addr", pmem_address, addr & 32'hFFFF_FFE0);
      end
    end
    check("resp_timeout", 32'(got), 32'd1);
    install(addr);
  endtask

  // Scoreboard monitor: every response pops one expectation.
  always @(negedge clk) begin
    if (reset || !inst_read) begin
      if (inst_resp) check("idle_resp", 32'(inst_resp), 32'd0);
      wait_cycles = 0;
    end else if (inst_resp) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(inst_resp), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rdata", inst_rdata, mon_e.data);
        check("latency", 32'(wait_cycles), 32'(mon_e.exp_wait));
      end
      wait_cycles = 0;
    end else begin
      wait_cycles++;
    end
  end

  initial begin
    logic [31:0] a;
    reset = 1'b1;
    inst_read = 1'b0;
    inst_addr = 32'h0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    #1;
    check("rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_inst_resp", 32'(inst_resp), 32'd0);
    check("rst_pmem_addr", pmem_address, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    fill_delay = 2;
    request(32'h0000_0064);
    for (int w = 32'h60; w <= 32'h7C; w += 4) request(32'(w));

    fill_delay = 1;
    request(32'h0000_0160);
    request(32'h0000_0060);

    // Withdrawal: drop the request in the second fetch cycle.
    request(32'h0000_0160);
    fill_delay = 3;
    inst_read = 1'b1;
    inst_addr = 32'h0000_0060;
    step();
    step();
    inst_read = 1'b0;
    inst_addr = 32'h0000_0200;
    for (int i = 0; i < 20 && pmem_read; i++) begin
      check("hold_addr", pmem_address, 32'h0000_0060);
      step();
    end
    check("withdraw_done", 32'(pmem_read), 32'd0);
    install(32'h0000_0060);
    request(32'h0000_0060);
    request(32'h0000_0068);

    // Stray response in IDLE must be ignored.
    inst_read = 1'b0;
    pmem_rdata = {8{32'hDEAD_BEEF}};
    pmem_resp = 1'b1;
    step();
    check("stray_no_fetch", 32'(pmem_read), 32'd0);
    request(32'h0000_006C);

    // Reset arriving together with the fill response.
    fill_delay = 0;
    request(32'h0000_0160);
    auto_resp = 1'b0;
    inst_read = 1'b1;
    inst_addr = 32'h0000_0060;
    step();
    check("rst_fill_req", 32'(pmem_read), 32'd1);
    pmem_rdata = mem_line(32'h0000_0060);
    pmem_resp = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_drop", 32'(pmem_read), 32'd0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    inst_read = 1'b0;
    reset = 1'b0;
    auto_resp = 1'b1;
    busy = 1'b0;
    resident.delete();
    request(32'h0000_0060);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        inst_read = 1'b0;
        step();
      end
      fill_delay = $urandom_range(0, 3);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      request(a);
    end

    inst_read = 1'b0;
    step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
